// File: rtl/fpg8_mem_pkg.sv
// Shared memory-subsystem constants: RAM geometry, arbiter FSM state codes, RAM owner codes.
// No logic; no latency.
// No flow control.
package fpg8_mem_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    localparam logic [1:0] ST_NORMAL    = 2'd0;
    localparam logic [1:0] ST_HOLD_PEND = 2'd1;
    localparam logic [1:0] ST_HOLD      = 2'd2;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LDR = 1'b1;

endpackage

// File: rtl/ram_arbiter_starve_counter.sv
// Saturating loader-wait counter with a clear input and a terminal (LIMIT-1) flag.
// One-cycle registered count; term is combinational from the count.
// No backpressure; inc is ignored once the count saturates at LIMIT.
module ram_arbiter_starve_counter #(
    parameter int CNT_W = 4,
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic term
);

    localparam logic [CNT_W-1:0] SAT_VAL  = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != SAT_VAL)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign term = (cnt == TERM_VAL);

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port RAM between the CPU path (fixed priority) and the loader/debug port.
// RAM mux and ldr_ack are combinational; ldr_rvalid, cpu_hold and conflict are registered.
// The CPU is never stalled per access; a starved or bulk loader forces cpu_hold instead.
import fpg8_mem_pkg::*;

module ram_arbiter #(
    parameter int ADDR_W       = fpg8_mem_pkg::ADDR_W,
    parameter int DATA_W       = fpg8_mem_pkg::DATA_W,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_r_en,
    input  logic              cpu_w_en,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_w_data,
    output logic [DATA_W-1:0] cpu_r_data,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_w_data,
    input  logic              ldr_hold_req,
    output logic              ldr_ack,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_r_data,
    output logic              cpu_hold,
    output logic              conflict,
    output logic              ram_r_en,
    output logic              ram_w_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_w_data,
    input  logic [DATA_W-1:0] ram_r_data
);

    logic [1:0] state;
    logic       cpu_act;
    logic       owner;
    logic       ldr_wait;
    logic       starve_term;

    always_comb begin
        cpu_act = cpu_r_en | cpu_w_en;
        owner   = cpu_act ? OWN_CPU : OWN_LDR;
        // A loader request seen during reset is dropped, not acked.
        ldr_ack = (owner == OWN_LDR) & ldr_req & ~reset;

        ram_addr   = ldr_addr;
        ram_w_data = ldr_w_data;
        ram_w_en   = 1'b0;
        ram_r_en   = 1'b0;
        if (owner == OWN_CPU) begin
            ram_addr   = cpu_addr;
            ram_w_data = cpu_w_data;
            ram_w_en   = cpu_w_en;
            ram_r_en   = cpu_r_en & ~cpu_w_en;
        end else if (ldr_ack) begin
            ram_w_en = ldr_we;
            ram_r_en = ~ldr_we;
        end
    end

    assign ldr_wait   = ldr_req & ~ldr_ack;
    assign cpu_r_data = ram_r_data;
    assign ldr_r_data = ram_r_data;

    ram_arbiter_starve_counter #(
        .CNT_W (CNT_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (~ldr_req | ldr_ack),
        .inc   (ldr_wait),
        .term  (starve_term)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_NORMAL;
            cpu_hold   <= 1'b0;
            ldr_rvalid <= 1'b0;
            conflict   <= 1'b0;
        end else begin
            ldr_rvalid <= ldr_ack & ~ldr_we;
            if ((cpu_act && (state == ST_HOLD)) || (cpu_r_en && cpu_w_en)) begin
                conflict <= 1'b1;
            end
            case (state)
                ST_NORMAL: begin
                    if ((starve_term && ldr_wait) || ldr_hold_req) begin
                        state    <= ST_HOLD_PEND;
                        cpu_hold <= 1'b1;
                    end
                end
                // CPU may still be finishing its last access when hold is raised.
                ST_HOLD_PEND: begin
                    if (!cpu_act) begin
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!ldr_hold_req && (ldr_ack || !ldr_req)) begin
                        state    <= ST_NORMAL;
                        cpu_hold <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_NORMAL;
                    cpu_hold <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 4096x16 registered-read RAM.
module tb_ram_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_r_en;
    logic        cpu_w_en;
    logic [11:0] cpu_addr;
    logic [15:0] cpu_w_data;
    logic [15:0] cpu_r_data;
    logic        ldr_req;
    logic        ldr_we;
    logic [11:0] ldr_addr;
    logic [15:0] ldr_w_data;
    logic        ldr_hold_req;
    logic        ldr_ack;
    logic        ldr_rvalid;
    logic [15:0] ldr_r_data;
    logic        cpu_hold;
    logic        conflict;
    logic        ram_r_en;
    logic        ram_w_en;
    logic [11:0] ram_addr;
    logic [15:0] ram_w_data;
    logic [15:0] ram_r_data;

    logic [15:0] mem [0:4095];

    int n_checks = 0;
    int n_fails  = 0;

    ram_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_r_en     (cpu_r_en),
        .cpu_w_en     (cpu_w_en),
        .cpu_addr     (cpu_addr),
        .cpu_w_data   (cpu_w_data),
        .cpu_r_data   (cpu_r_data),
        .ldr_req      (ldr_req),
        .ldr_we       (ldr_we),
        .ldr_addr     (ldr_addr),
        .ldr_w_data   (ldr_w_data),
        .ldr_hold_req (ldr_hold_req),
        .ldr_ack      (ldr_ack),
        .ldr_rvalid   (ldr_rvalid),
        .ldr_r_data   (ldr_r_data),
        .cpu_hold     (cpu_hold),
        .conflict     (conflict),
        .ram_r_en     (ram_r_en),
        .ram_w_en     (ram_w_en),
        .ram_addr     (ram_addr),
        .ram_w_data   (ram_w_data),
        .ram_r_data   (ram_r_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (ram_w_en) mem[ram_addr] <= ram_w_data;
        if (ram_r_en) ram_r_data <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[12'h010] = 16'h1234;
        ram_r_data   = 16'h0000;
        reset        = 1'b1;
        cpu_r_en     = 1'b0;
        cpu_w_en     = 1'b0;
        cpu_addr     = 12'h000;
        cpu_w_data   = 16'h0000;
        ldr_req      = 1'b0;
        ldr_we       = 1'b0;
        ldr_addr     = 12'h000;
        ldr_w_data   = 16'h0000;
        ldr_hold_req = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_cpu_hold", 32'(cpu_hold), 0);
        chk("rst_rvalid",   32'(ldr_rvalid), 0);
        chk("rst_conflict", 32'(conflict), 0);
        chk("rst_ack",      32'(ldr_ack), 0);
        chk("rst_ram_en",   32'({ram_r_en, ram_w_en}), 0);
        reset = 1'b0;
        tick();

        // 1: CPU-only read
        cpu_r_en = 1'b1;
        cpu_addr = 12'h010;
        settle();
        chk("t1_ram_r_en", 32'(ram_r_en), 1);
        chk("t1_ram_addr", 32'(ram_addr), 'h010);
        chk("t1_ack",      32'(ldr_ack), 0);
        tick();
        cpu_r_en = 1'b0;
        chk("t1_r_data", 32'(cpu_r_data), 'h1234);

        // 2: idle CPU, loader write then read
        ldr_req    = 1'b1;
        ldr_we     = 1'b1;
        ldr_addr   = 12'h0FF;
        ldr_w_data = 16'hBEEF;
        settle();
        chk("t2_wr_ack",  32'(ldr_ack), 1);
        chk("t2_wr_wen",  32'({ram_w_en, ram_r_en}), 'b10);
        chk("t2_wr_addr", 32'(ram_addr), 'h0FF);
        tick();
        ldr_we = 1'b0;
        settle();
        chk("t2_rd_ack",    32'(ldr_ack), 1);
        chk("t2_rd_ren",    32'({ram_w_en, ram_r_en}), 'b01);
        chk("t2_rvalid_lo", 32'(ldr_rvalid), 0);
        tick();
        ldr_req = 1'b0;
        chk("t2_rvalid",  32'(ldr_rvalid), 1);
        chk("t2_rd_data", 32'(ldr_r_data), 'hBEEF);
        tick();
        chk("t2_rvalid_end", 32'(ldr_rvalid), 0);

        // 3: CPU busy every cycle, loader starves for 8 cycles
        cpu_r_en   = 1'b1;
        cpu_addr   = 12'h010;
        ldr_req    = 1'b1;
        ldr_we     = 1'b1;
        ldr_addr   = 12'h100;
        ldr_w_data = 16'h5555;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk($sformatf("t3_wait%0d_ack", i), 32'(ldr_ack), 0);
            chk($sformatf("t3_wait%0d_hold", i), 32'(cpu_hold), 0);
            tick();
        end
        chk("t3_hold_set", 32'(cpu_hold), 1);
        chk("t3_pend_ack", 32'(ldr_ack), 0);
        tick();
        cpu_r_en = 1'b0;
        settle();
        chk("t3_idle_ack",  32'(ldr_ack), 1);
        chk("t3_idle_addr", 32'(ram_addr), 'h100);
        tick();
        ldr_req = 1'b0;
        tick();
        chk("t3_hold_rel", 32'(cpu_hold), 0);
        chk("t3_conflict", 32'(conflict), 0);

        // 4: bulk load of 16 words under ldr_hold_req
        ldr_hold_req = 1'b1;
        ldr_req      = 1'b1;
        ldr_we       = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ldr_addr   = 12'(i);
            ldr_w_data = 16'hA000 + 16'(i);
            settle();
            chk($sformatf("t4_ack%0d", i), 32'(ldr_ack), 1);
            tick();
            chk($sformatf("t4_hold%0d", i), 32'(cpu_hold), 1);
        end
        ldr_req      = 1'b0;
        ldr_hold_req = 1'b0;
        tick();
        chk("t4_hold_rel", 32'(cpu_hold), 0);
        ldr_req  = 1'b1;
        ldr_we   = 1'b0;
        ldr_addr = 12'h00F;
        tick();
        ldr_req = 1'b0;
        chk("t4_rd_valid", 32'(ldr_rvalid), 1);
        chk("t4_rd_data",  32'(ldr_r_data), 'hA00F);
        chk("t3_wr_mem",   32'(mem[12'h100]), 'h5555);

        // 5a: CPU write during HOLD
        ldr_hold_req = 1'b1;
        tick();
        tick();
        chk("t5_in_hold", 32'(cpu_hold), 1);
        cpu_w_en   = 1'b1;
        cpu_addr   = 12'h200;
        cpu_w_data = 16'h7777;
        settle();
        chk("t5_wen",      32'({ram_w_en, ram_r_en}), 'b10);
        chk("t5_addr",     32'(ram_addr), 'h200);
        chk("t5_wdata",    32'(ram_w_data), 'h7777);
        chk("t5_conf_pre", 32'(conflict), 0);
        tick();
        cpu_w_en = 1'b0;
        chk("t5_conflict", 32'(conflict), 1);
        tick();
        chk("t5_conf_sticky", 32'(conflict), 1);

        // 6: reset while in HOLD_PEND with a loader read pending
        ldr_hold_req = 1'b0;
        tick();
        chk("t6_normal", 32'(cpu_hold), 0);
        ldr_hold_req = 1'b1;
        cpu_r_en     = 1'b1;
        cpu_addr     = 12'h010;
        ldr_req      = 1'b1;
        ldr_we       = 1'b0;
        ldr_addr     = 12'h200;
        tick();
        chk("t6_pend_hold", 32'(cpu_hold), 1);
        cpu_r_en = 1'b0;
        reset    = 1'b1;
        settle();
        chk("t6_rst_ack", 32'(ldr_ack), 0);
        tick();
        chk("t6_hold",     32'(cpu_hold), 0);
        chk("t6_rvalid",   32'(ldr_rvalid), 0);
        chk("t6_conflict", 32'(conflict), 0);
        reset        = 1'b0;
        ldr_hold_req = 1'b0;
        settle();
        chk("t6_post_ack", 32'(ldr_ack), 1);
        tick();
        ldr_req = 1'b0;
        chk("t6_post_rvalid", 32'(ldr_rvalid), 1);
        chk("t6_post_data",   32'(ldr_r_data), 'h7777);

        // 5b: simultaneous CPU read and write enables
        cpu_r_en   = 1'b1;
        cpu_w_en   = 1'b1;
        cpu_addr   = 12'h300;
        cpu_w_data = 16'h4242;
        settle();
        chk("t5b_en", 32'({ram_w_en, ram_r_en}), 'b10);
        tick();
        cpu_w_en = 1'b0;
        chk("t5b_conflict", 32'(conflict), 1);
        tick();
        cpu_r_en = 1'b0;
        chk("t5b_rd_data", 32'(cpu_r_data), 'h4242);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
